// File: rtl/tile_seq_if.sv
// Sequencer bus: launch/abort, per-run configuration, segment-done pulses
// from the datapath engines, and the sequencer status outputs.
interface tile_seq_if #(
   parameter int STATE_W = 3,
   parameter int BASE_W  = 6,
   parameter int ROW_W   = 8
);
   logic               start;
   logic               abort;
   logic [BASE_W-1:0]  cfg_base_number;
   logic [ROW_W-1:0]   cfg_row_number;
   logic               cfg_reload_per_row;
   logic               flag_fsld_end;
   logic               left_done;
   logic               base_done;
   logic               right_done;
   logic [STATE_W-1:0] curr_state;
   logic [BASE_W-1:0]  base_idx;
   logic [ROW_W-1:0]   row_idx;
   logic               busy;
   logic               all_done;
   logic               proto_err;

   // Sequencer side
   modport master (
      input  start, abort, cfg_base_number, cfg_row_number, cfg_reload_per_row,
      input  flag_fsld_end, left_done, base_done, right_done,
      output curr_state, base_idx, row_idx, busy, all_done, proto_err
   );

   // Host / engine side
   modport slave (
      output start, abort, cfg_base_number, cfg_row_number, cfg_reload_per_row,
      output flag_fsld_end, left_done, base_done, right_done,
      input  curr_state, base_idx, row_idx, busy, all_done, proto_err
   );
endinterface

// File: rtl/tile_seq_fsm.sv
// Row/segment sequencer for the MAC-array DLA.
//
//   state | meaning
//   IDLE  | waiting for start; config is latched on start
//   FSLD  | first (or per-row) SRAM load in progress
//   LEFT  | left edge segment of the current row
//   BASE  | base segment base_idx of the current row
//   RIGHT | right edge segment of the current row
//   DONE  | last row finished; all_done is high for this one cycle
//
// Codes 5 and 6 are unused and fall back to IDLE.
module tile_seq_fsm #(
   parameter int STATE_W = 3,
   parameter int BASE_W  = 6,
   parameter int ROW_W   = 8
) (
   input  logic       clk,
   input  logic       reset,
   tile_seq_if.master bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEFT  = 3'd1,
      BASE  = 3'd2,
      RIGHT = 3'd3,
      DONE  = 3'd4,
      FSLD  = 3'd7
   } state_t;

   state_t            state_q, state_d;
   logic [BASE_W-1:0] base_idx_q, base_idx_d;
   logic [ROW_W-1:0]  row_idx_q, row_idx_d;
   logic [BASE_W-1:0] base_num_q, base_num_d;
   logic [ROW_W-1:0]  row_num_q, row_num_d;
   logic              reload_q, reload_d;
   logic              all_done_q, all_done_d;
   logic              proto_err_q, proto_err_d;

   logic [3:0] pulses;
   logic [3:0] expect_mask;
   logic [3:0] act;
   logic       err_now;

   // Classify this cycle's pulses: which one the current state accepts, and whether anything is off-protocol
   always_comb begin
      pulses      = {bus.flag_fsld_end, bus.left_done, bus.base_done, bus.right_done};
      expect_mask = 4'b0000;
      case (state_q)
         FSLD:    expect_mask = 4'b1000;
         LEFT:    expect_mask = 4'b0100;
         BASE:    expect_mask = 4'b0010;
         RIGHT:   expect_mask = 4'b0001;
         default: expect_mask = 4'b0000;
      endcase
      act     = pulses & expect_mask;
      err_now = ((pulses & (pulses - 4'd1)) != 4'd0)
              | ((pulses & ~expect_mask) != 4'd0)
              | (bus.start && (state_q != IDLE));
   end

   // Next-state, index and flag logic; abort overrides any done pulse
   always_comb begin
      state_d     = state_q;
      base_idx_d  = base_idx_q;
      row_idx_d   = row_idx_q;
      base_num_d  = base_num_q;
      row_num_d   = row_num_q;
      reload_d    = reload_q;
      all_done_d  = 1'b0;
      proto_err_d = proto_err_q | err_now;

      if (bus.abort) begin
         if (state_q != IDLE) begin
            state_d    = IDLE;
            base_idx_d = '0;
            row_idx_d  = '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d     = FSLD;
                  base_idx_d  = '0;
                  row_idx_d   = '0;
                  base_num_d  = bus.cfg_base_number;
                  row_num_d   = bus.cfg_row_number;
                  reload_d    = bus.cfg_reload_per_row;
                  proto_err_d = err_now;
               end
            end
            FSLD: begin
               if (act[3]) state_d = LEFT;
            end
            LEFT: begin
               if (act[2]) begin
                  if (base_num_q == '0) begin
                     state_d = RIGHT;
                  end else begin
                     state_d    = BASE;
                     base_idx_d = '0;
                  end
               end
            end
            BASE: begin
               if (act[1]) begin
                  if (base_idx_q == base_num_q - BASE_W'(1)) begin
                     state_d = RIGHT;
                  end else begin
                     base_idx_d = base_idx_q + BASE_W'(1);
                  end
               end
            end
            RIGHT: begin
               if (act[0]) begin
                  if (row_idx_q == row_num_q) begin
                     state_d    = DONE;
                     all_done_d = 1'b1;
                  end else begin
                     row_idx_d  = row_idx_q + ROW_W'(1);
                     base_idx_d = '0;
                     state_d    = reload_q ? FSLD : LEFT;
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d    = IDLE;
               base_idx_d = '0;
               row_idx_d  = '0;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         base_idx_q  <= '0;
         row_idx_q   <= '0;
         base_num_q  <= '0;
         row_num_q   <= '0;
         reload_q    <= 1'b0;
         all_done_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_idx_q  <= base_idx_d;
         row_idx_q   <= row_idx_d;
         base_num_q  <= base_num_d;
         row_num_q   <= row_num_d;
         reload_q    <= reload_d;
         all_done_q  <= all_done_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign bus.curr_state = STATE_W'(state_q);
   assign bus.base_idx   = base_idx_q;
   assign bus.row_idx    = row_idx_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.all_done   = all_done_q;
   assign bus.proto_err  = proto_err_q;

endmodule
